sap_1_control_sequencer: RTL and testbench

SAP_1_CONTROL_SEQUENCER -- requirements
Module: sap_1_control_sequencer

---
 rtl/sap_1_pkg.sv | 47 ++++
 rtl/sap_1_ring_counter.sv | 38 +++
 rtl/sap_1_control_sequencer.sv | 77 +++++++
 tb/tb_sap_1_control_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_1_pkg.sv
// Shared constants for the SAP-1 control sequencer: control-word bit positions,
// control words, opcodes and ring-counter state encodings.
package sap_1_pkg;

    // con bit positions, MSB first: {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
    localparam int unsigned CON_CP   = 11;
    localparam int unsigned CON_EP   = 10;
    localparam int unsigned CON_LM_N = 9;
    localparam int unsigned CON_CE_N = 8;
    localparam int unsigned CON_LI_N = 7;
    localparam int unsigned CON_EI_N = 6;
    localparam int unsigned CON_LA_N = 5;
    localparam int unsigned CON_EA   = 4;
    localparam int unsigned CON_SU   = 3;
    localparam int unsigned CON_EU   = 2;
    localparam int unsigned CON_LB_N = 1;
    localparam int unsigned CON_LO_N = 0;

    localparam logic [11:0] CON_IDLE = 12'h3E3;

    localparam logic [11:0] CON_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CON_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CON_FETCH_T3 = 12'h263;

    localparam logic [11:0] CON_MEM_ADDR = 12'h1A3;  // shared T4 of LDA/ADD/SUB
    localparam logic [11:0] CON_LDA_T5   = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5   = 12'h2E1;  // shared T5 of ADD/SUB
    localparam logic [11:0] CON_ADD_T6   = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6   = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4   = 12'h3F2;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Ring positions; IDLE and HALT both present an all-zero ring.
    localparam logic [5:0] ST_IDLE = 6'b000000;
    localparam logic [5:0] ST_T1   = 6'b000001;
    localparam logic [5:0] ST_T2   = 6'b000010;
    localparam logic [5:0] ST_T3   = 6'b000100;
    localparam logic [5:0] ST_T4   = 6'b001000;
    localparam logic [5:0] ST_T5   = 6'b010000;
    localparam logic [5:0] ST_T6   = 6'b100000;

endpackage

// File: rtl/sap_1_ring_counter.sv
// One-hot T1..T6 ring counter. An all-zero ring starts at T1 on the first enabled edge;
// park forces the ring back to all-zero.
module sap_1_ring_counter
    import sap_1_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic       park,
    output logic [5:0] ring
);

    logic [5:0] ring_q, ring_d;

    always_comb begin
        ring_d = ring_q;
        if (park) begin
            ring_d = ST_IDLE;
        end else if (en) begin
            if (ring_q == ST_IDLE) begin
                ring_d = ST_T1;
            end else begin
                ring_d = {ring_q[4:0], ring_q[5]};
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ring_q <= ST_IDLE;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/sap_1_control_sequencer.sv
// SAP-1 control sequencer: steps a six-phase ring per instruction and decodes the
// 12-bit control word from ring position and opcode while the sequencer is advancing.
module sap_1_control_sequencer
    import sap_1_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        hlt
);

    logic       adv;
    logic       go_halt;
    logic       halt_q;
    logic [5:0] ring;

    assign adv     = run | step;
    assign go_halt = adv & ~halt_q & (ring == ST_T4) & (opcode == OP_HLT);

    sap_1_ring_counter u_ring (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (adv & ~halt_q & ~go_halt),
        .park  (go_halt),
        .ring  (ring)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            halt_q <= 1'b0;
        end else if (go_halt) begin
            halt_q <= 1'b1;
        end
    end

    // A paused sequencer drives the idle word; the held phase's word appears once adv returns.
    always_comb begin
        con = CON_IDLE;
        if (adv && !halt_q) begin
            case (ring)
                ST_T1: con = CON_FETCH_T1;
                ST_T2: con = CON_FETCH_T2;
                ST_T3: con = CON_FETCH_T3;
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: con = CON_MEM_ADDR;
                        OP_OUT:                 con = CON_OUT_T4;
                        default:                con = CON_IDLE;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA:         con = CON_LDA_T5;
                        OP_ADD, OP_SUB: con = CON_ALU_T5;
                        default:        con = CON_IDLE;
                    endcase
                end
                ST_T6: begin
                    case (opcode)
                        OP_ADD:  con = CON_ADD_T6;
                        OP_SUB:  con = CON_SUB_T6;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

    assign t_state = ring;
    assign hlt     = halt_q;

endmodule

// File: tb/tb_sap_1_control_sequencer.sv
// Bench for sap_1_control_sequencer: directed literal scenarios plus randomized traffic,
// all checked every cycle against a position-counting behavioural model.
module tb_sap_1_control_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        run;
    logic        step;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        hlt;

    int total = 0;
    int bad   = 0;

    // Model position: 0 = idle, 1..6 = T1..T6, 7 = halted.
    int pos = 0;
    int halt_cycles = 0;

    always #5 clk = ~clk;

    sap_1_control_sequencer dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .run     (run),
        .step    (step),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .hlt     (hlt)
    );

    function automatic logic [11:0] exp_con(int p, logic [3:0] op, logic a);
        logic [11:0] w [3];
        if (!a || p < 1 || p > 6) return 12'h3E3;
        if (p == 1) return 12'h5E3;
        if (p == 2) return 12'hBE3;
        if (p == 3) return 12'h263;
        case (op)
            4'h0:    w = '{12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    w = '{12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    w = '{12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    w = '{12'h3F2, 12'h3E3, 12'h3E3};
            default: w = '{12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return w[p-4];
    endfunction

    function automatic logic [5:0] exp_ts(int p);
        logic [5:0] one = 6'b000001;
        if (p < 1 || p > 6) return 6'b0;
        return one << (p - 1);
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pos = 0;
        end else if (pos != 7 && (run | step)) begin
            if (pos == 0)                        pos = 1;
            else if (pos == 4 && opcode == 4'hF) pos = 7;
            else if (pos == 6)                   pos = 1;
            else                                 pos = pos + 1;
        end
    end

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_con", con, exp_con(pos, opcode, run | step));
        check("model_tstate", {6'b0, t_state}, {6'b0, exp_ts(pos)});
        check("model_hlt", {11'b0, hlt}, {11'b0, (pos == 7)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #1 clr_n = 1'b0;
        #1 clr_n = 1'b1;
    endtask

    logic [11:0] seq033 [6];
    logic [5:0]  ts033  [6];

    initial begin
        seq033 = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3};
        ts033  = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
        clr_n = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'h0;
        #12;
        check("reset_con", con, 12'h3E3);
        check("reset_ts", {6'b0, t_state}, 12'h000);
        check("reset_hlt", {11'b0, hlt}, 12'h000);
        clr_n = 1'b1;
        run = 1'b1;

        // LDA full instruction and wrap to T1
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lda_con", con, seq033[i]);
            check("lda_ts", {6'b0, t_state}, {6'b0, ts033[i]});
        end
        tick();
        check("lda_wrap_ts", {6'b0, t_state}, 12'h001);
        check("lda_wrap_con", con, 12'h5E3);

        // SUB and ADD T6 words
        opcode = 4'h2;
        repeat (5) tick();
        check("sub_t6", con, 12'h3CF);
        tick();
        opcode = 4'h1;
        repeat (5) tick();
        check("add_t6", con, 12'h3C7);

        // Unknown opcode behaves as NOP
        tick();
        opcode = 4'h7;
        repeat (3) tick();
        check("nop_t4", con, 12'h3E3);
        tick();
        check("nop_t5", con, 12'h3E3);
        tick();
        check("nop_t6", con, 12'h3E3);
        check("nop_t6_ts", {6'b0, t_state}, 12'h020);
        tick();
        check("nop_wrap", {6'b0, t_state}, 12'h001);

        // Pause at T2, then single step
        tick();
        run = 1'b0;
        #1;
        check("pause_con", con, 12'h3E3);
        repeat (5) tick();
        check("pause_ts", {6'b0, t_state}, 12'h002);
        step = 1'b1;
        #1;
        check("step_con", con, 12'hBE3);
        tick();
        step = 1'b0;
        check("step_ts", {6'b0, t_state}, 12'h004);
        run = 1'b1;

        // Asynchronous reset during T5
        tick();
        tick();
        check("pre_reset_ts", {6'b0, t_state}, 12'h010);
        #1 clr_n = 1'b0;
        #1;
        check("async_ts", {6'b0, t_state}, 12'h000);
        check("async_con", con, 12'h3E3);
        #1 clr_n = 1'b1;
        tick();
        check("after_reset_ts", {6'b0, t_state}, 12'h001);

        // HLT: halts after T4 and ignores run/step
        opcode = 4'hF;
        repeat (3) tick();
        check("hlt_t4_con", con, 12'h3E3);
        check("hlt_t4_ts", {6'b0, t_state}, 12'h008);
        tick();
        check("hlt_flag", {11'b0, hlt}, 12'h001);
        check("hlt_ts", {6'b0, t_state}, 12'h000);
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            tick();
            check("hlt_hold", {hlt, t_state, 5'b0}, {1'b1, 6'b0, 5'b0});
            check("hlt_con", con, 12'h3E3);
        end
        step = 1'b0;
        reset_pulse();
        opcode = 4'h0;

        // Randomized traffic checked by the model process
        for (int c = 0; c < 3000; c++) begin
            tick();
            run  = ($urandom % 4) != 0;
            step = $urandom % 2;
            if (pos <= 3) begin
                opcode = 4'($urandom % 16);
                if (opcode == 4'hF && ($urandom % 4) != 0) opcode = 4'($urandom % 3);
            end
            if (pos == 7) halt_cycles++;
            if (halt_cycles > 4 || ($urandom % 300) == 0) begin
                halt_cycles = 0;
                reset_pulse();
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
